// File: rtl/dac_spi_multi.sv
// dac_spi_multi: multi-channel SPI driver for 12-bit Pmod DACs (DAC121S101 class).
// One frame per accepted valid/ready handshake. All channels shift in lockstep on a
// shared SCLK/SYNC, with one data line per channel, followed by a fixed SYNC-high gap.
module dac_spi_multi #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned FRAME_W  = 16,
    parameter int unsigned CLK_DIV  = 1,
    parameter int unsigned GAP_CYC  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*DATA_W-1:0]   data_in,
    input  logic [1:0]                   mode,
    input  logic                         valid,
    output logic                         ready,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         sclk,
    output logic                         sync_n,
    output logic [CHANNELS-1:0]          sdata
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(FRAME_W + 1);
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    if (FRAME_W < DATA_W + 2) begin : g_bad_frame_w
        $error("dac_spi_multi: FRAME_W must be >= DATA_W+2");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("dac_spi_multi: CLK_DIV must be >= 1");
    end
    if (GAP_CYC < 1) begin : g_bad_gap_cyc
        $error("dac_spi_multi: GAP_CYC must be >= 1");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("dac_spi_multi: CHANNELS must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t             r_state;
    logic               r_armed;
    logic [FRAME_W-1:0] r_shift [CHANNELS];
    logic [DIV_W-1:0]   r_div;
    logic [BIT_W-1:0]   r_bit;
    logic [GAP_W-1:0]   r_gap;
    logic               r_sclk;
    logic               r_sync_n;
    logic               r_done;
    logic               w_accept;

    // r_armed holds ready low for the first edge after reset even though the state is IDLE
    assign ready      = r_armed && (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign w_accept   = valid && ready;
    assign sclk       = r_sclk;
    assign sync_n     = r_sync_n;
    assign frame_done = r_done;

    // Serial data is the MSB of each shift register; registers are cleared outside SHIFT
    always_comb begin
        sdata = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            sdata[k] = r_shift[k][FRAME_W-1];
        end
    end

    // Frame sequencer: accept, divide SCLK, shift on rising edges, then hold the gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_armed  <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
            r_gap    <= '0;
            r_sclk   <= 1'b1;
            r_sync_n <= 1'b1;
            r_done   <= 1'b0;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                r_shift[k] <= '0;
            end
        end else begin
            r_armed <= 1'b1;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        for (int unsigned k = 0; k < CHANNELS; k++) begin
                            r_shift[k] <= FRAME_W'({mode, data_in[k*DATA_W +: DATA_W]});
                        end
                        r_div    <= '0;
                        r_bit    <= '0;
                        r_sclk   <= 1'b1;
                        r_sync_n <= 1'b0;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        if (r_sclk) begin
                            r_sclk <= 1'b0;
                            r_bit  <= r_bit + 1'b1;
                        end else if (r_bit == BIT_LAST) begin
                            // Final rising edge closes the frame instead of shifting
                            r_sclk   <= 1'b1;
                            r_sync_n <= 1'b1;
                            r_done   <= 1'b1;
                            r_gap    <= '0;
                            r_state  <= S_GAP;
                            for (int unsigned k = 0; k < CHANNELS; k++) begin
                                r_shift[k] <= '0;
                            end
                        end else begin
                            r_sclk <= 1'b1;
                            for (int unsigned k = 0; k < CHANNELS; k++) begin
                                r_shift[k] <= {r_shift[k][FRAME_W-2:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_gap   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_multi.sv
// Testbench for dac_spi_multi: a default 2-channel instance (A) and a 4-channel,
// CLK_DIV=3, GAP_CYC=5 instance (B), checked against a frame-level reference model.
module tb_dac_spi_multi;

    localparam int FW    = 16;
    localparam int CD_A  = 1;
    localparam int GAP_A = 1;
    localparam int CH_A  = 2;
    localparam int CD_B  = 3;
    localparam int GAP_B = 5;
    localparam int CH_B  = 4;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic        a_rst_n, a_valid, a_ready, a_busy, a_done, a_sclk, a_sync_n;
    logic [23:0] a_data;
    logic [1:0]  a_mode;
    logic [1:0]  a_sdata;

    logic        b_rst_n, b_valid, b_ready, b_busy, b_done, b_sclk, b_sync_n;
    logic [47:0] b_data;
    logic [1:0]  b_mode;
    logic [3:0]  b_sdata;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dac_spi_multi u_dut_a (
        .clk        (clk),
        .rst_n      (a_rst_n),
        .data_in    (a_data),
        .mode       (a_mode),
        .valid      (a_valid),
        .ready      (a_ready),
        .busy       (a_busy),
        .frame_done (a_done),
        .sclk       (a_sclk),
        .sync_n     (a_sync_n),
        .sdata      (a_sdata)
    );

    dac_spi_multi #(
        .CHANNELS (CH_B),
        .DATA_W   (12),
        .FRAME_W  (FW),
        .CLK_DIV  (CD_B),
        .GAP_CYC  (GAP_B)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (b_rst_n),
        .data_in    (b_data),
        .mode       (b_mode),
        .valid      (b_valid),
        .ready      (b_ready),
        .busy       (b_busy),
        .frame_done (b_done),
        .sclk       (b_sclk),
        .sync_n     (b_sync_n),
        .sdata      (b_sdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Both instances viewed through common arrays so one monitor serves them
    logic        m_sclk [2], m_sync [2], m_ready [2], m_busy [2], m_done [2], m_valid [2], m_rst [2];
    logic [3:0]  m_sdata [2];
    logic [47:0] m_data [2];
    logic [1:0]  m_mode [2];

    always_comb begin
        m_sclk[0]  = a_sclk;   m_sclk[1]  = b_sclk;
        m_sync[0]  = a_sync_n; m_sync[1]  = b_sync_n;
        m_ready[0] = a_ready;  m_ready[1] = b_ready;
        m_busy[0]  = a_busy;   m_busy[1]  = b_busy;
        m_done[0]  = a_done;   m_done[1]  = b_done;
        m_valid[0] = a_valid;  m_valid[1] = b_valid;
        m_rst[0]   = a_rst_n;  m_rst[1]   = b_rst_n;
        m_sdata[0] = {2'b00, a_sdata};
        m_sdata[1] = b_sdata;
        m_data[0]  = {24'h0, a_data};
        m_data[1]  = b_data;
        m_mode[0]  = a_mode;
        m_mode[1]  = b_mode;
    end

    int          acc_t [2]     = '{0, 0};
    int          acc_cnt [2]   = '{0, 0};
    int          falls [2]     = '{0, 0};
    int          last_fall [2] = '{0, 0};
    int          edges [2]     = '{0, 0};
    int          inv_bad [2]   = '{0, 0};
    logic        pend [2]      = '{1'b0, 1'b0};
    logic        had [2]       = '{1'b0, 1'b0};
    logic        vhold [2]     = '{1'b0, 1'b0};
    logic        p_sclk [2]    = '{1'b1, 1'b1};
    logic        p_sync [2]    = '{1'b1, 1'b1};
    logic        p_ready [2]   = '{1'b0, 1'b0};
    logic        p_done [2]    = '{1'b0, 1'b0};
    logic [63:0] cap [2]       = '{64'h0, 64'h0};
    logic [63:0] expw [2]      = '{64'h0, 64'h0};
    logic [63:0] last_cap [2]  = '{64'h0, 64'h0};

    // Reference model: predicts each frame from the inputs at its accept cycle and
    // decodes the pins as the DAC would (sample on SCLK falling edges while SYNC low)
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int cd, gp, nch, per;
            cd  = (d == 0) ? CD_A : CD_B;
            gp  = (d == 0) ? GAP_A : GAP_B;
            nch = (d == 0) ? CH_A : CH_B;
            per = 2 * cd * FW + gp;
            if (m_sclk[d] != p_sclk[d]) edges[d]++;
            if (!m_rst[d]) begin
                pend[d]  = 1'b0;
                had[d]   = 1'b0;
                vhold[d] = 1'b0;
                falls[d] = 0;
                cap[d]   = '0;
                if (m_done[d]) inv_bad[d]++;
            end else begin
                if ((m_sync[d] && (!m_sclk[d] || m_sdata[d] != 4'h0)) ||
                    (!m_sync[d] && m_ready[d]) || (m_ready[d] && m_busy[d]))
                    inv_bad[d]++;
                if (m_done[d]) begin
                    check("done_pending", pend[d], 1);
                    check("done_cycle", cyc, acc_t[d] + 2 * cd * FW);
                    check("done_single", p_done[d], 0);
                end
                if (p_sclk[d] && !m_sclk[d] && !m_sync[d]) begin
                    if (falls[d] == 0) check("first_fall", cyc, acc_t[d] + cd);
                    else check("sclk_period", cyc - last_fall[d], 2 * cd);
                    last_fall[d] = cyc;
                    falls[d]++;
                    for (int k = 0; k < nch; k++)
                        cap[d][k*16 +: 16] = {cap[d][k*16 +: 15], m_sdata[d][k]};
                end
                if (!p_sync[d] && m_sync[d]) begin
                    check("bit_count", falls[d], FW);
                    check("frame_word", cap[d], expw[d]);
                    check("done_at_end", m_done[d], 1);
                    last_cap[d] = cap[d];
                    pend[d]     = 1'b0;
                    falls[d]    = 0;
                    cap[d]      = '0;
                end
                if (!p_ready[d] && m_ready[d] && had[d])
                    check("ready_return", cyc, acc_t[d] + per);
                if (m_valid[d] && m_ready[d]) begin
                    if (vhold[d]) check("accept_spacing", cyc + 1 - acc_t[d], per + 1);
                    acc_t[d] = cyc + 1;
                    acc_cnt[d]++;
                    pend[d]  = 1'b1;
                    had[d]   = 1'b1;
                    vhold[d] = 1'b1;
                    expw[d]  = '0;
                    for (int k = 0; k < nch; k++)
                        expw[d][k*16 +: 16] = {2'b00, m_mode[d], m_data[d][k*12 +: 12]};
                end else if (!m_valid[d]) begin
                    vhold[d] = 1'b0;
                end
            end
            p_sclk[d]  = m_sclk[d];
            p_sync[d]  = m_sync[d];
            p_ready[d] = m_ready[d];
            p_done[d]  = m_done[d];
        end
    end

    task automatic wait_idle(input int d, input int lim);
        int i = 0;
        @(negedge clk);
        while (!(m_ready[d] && !m_busy[d]) && i < lim) begin
            @(negedge clk);
            i++;
        end
        check("wait_idle", m_ready[d] && !m_busy[d], 1);
    endtask

    task automatic pulse_a(input logic [23:0] data, input logic [1:0] md);
        @(posedge clk); #1;
        a_data  = data;
        a_mode  = md;
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic pulse_b(input logic [47:0] data, input logic [1:0] md);
        @(posedge clk); #1;
        b_data  = data;
        b_mode  = md;
        b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    initial begin
        int e0, e1, n0, i;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        a_data  = '0;   b_data  = '0;
        a_mode  = '0;   b_mode  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a_outs", {a_sclk, a_sync_n, a_sdata, a_ready, a_busy, a_done}, 7'b1100000);
        check("reset_b_outs", {b_sclk, b_sync_n, b_sdata, b_ready, b_busy, b_done}, 9'b110000000);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_edge", a_ready, 0);
        @(posedge clk); #1;
        check("ready_first_edge_a", a_ready, 1);
        check("ready_first_edge_b", b_ready, 1);

        // idle with valid low: no SCLK activity
        e0 = edges[0]; e1 = edges[1];
        repeat (40) @(posedge clk);
        #1;
        check("idle_edges_a", edges[0] - e0, 0);
        check("idle_edges_b", edges[1] - e1, 0);
        check("idle_pins_a", {a_sclk, a_sync_n, a_ready}, 3'b111);

        // single directed frame on the default instance
        pulse_a({12'hFFF, 12'h0A5}, 2'b00);
        wait_idle(0, 200);
        check("directed_words_a", last_cap[0][31:0], 32'h0FFF_00A5);

        // inputs toggled every cycle while the frame is shifting
        pulse_a(24'($urandom), 2'($urandom));
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            a_data = 24'($urandom);
            a_mode = 2'($urandom);
        end
        wait_idle(0, 200);

        // valid held high, data changing every cycle: back-to-back frames
        n0 = acc_cnt[0];
        i  = 0;
        @(posedge clk); #1;
        a_valid = 1'b1;
        while (acc_cnt[0] < n0 + 4 && i < 400) begin
            @(posedge clk); #1;
            a_data = 24'($urandom);
            a_mode = 2'($urandom);
            i++;
        end
        a_valid = 1'b0;
        check("streamed_accepts_a", acc_cnt[0] - n0, 4);
        wait_idle(0, 200);

        // reset asserted in the middle of a frame
        pulse_a(24'($urandom), 2'($urandom));
        i = 0;
        while (falls[0] < 7 && i < 200) begin
            @(negedge clk); #1;
            i++;
        end
        check("midreset_reached_bit7", falls[0], 7);
        a_rst_n = 1'b0;
        #1;
        check("midreset_outs", {a_sclk, a_sync_n, a_sdata, a_ready, a_busy, a_done}, 7'b1100000);
        repeat (3) @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        @(posedge clk); #1;
        for (int f = 0; f < 3; f++) begin
            pulse_a(24'($urandom), 2'($urandom));
            wait_idle(0, 200);
        end

        // 4-channel instance: directed codes with valid held for two frames
        n0 = acc_cnt[1];
        i  = 0;
        @(posedge clk); #1;
        b_data  = {12'hFFF, 12'h800, 12'h001, 12'h000};
        b_mode  = 2'b11;
        b_valid = 1'b1;
        while (acc_cnt[1] < n0 + 2 && i < 400) begin
            @(posedge clk); #1;
            i++;
        end
        b_valid = 1'b0;
        check("b_accepts", acc_cnt[1] - n0, 2);
        wait_idle(1, 400);
        check("directed_words_b", last_cap[1], 64'h3FFF_3800_3001_3000);
        for (int f = 0; f < 3; f++) begin
            pulse_b({$urandom, 16'($urandom)}, 2'($urandom));
            wait_idle(1, 400);
        end

        check("pin_invariants_a", inv_bad[0], 0);
        check("pin_invariants_b", inv_bad[1], 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
